uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the next-generation receive path. Adds configurable frame format (data bits, parity, stop bits), glitch rejection, framing and parity error detection, and a first-word-fall-through receive FIFO with overrun reporting. The block sits between the rx pin and the display and consumer logic (LED and 7-segment drivers). Consumers pop characters at their own pace, so they no longer have to catch a one-cycle ready pulse.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 9600, bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be ≥ 4.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 8, receive FIFO entries, power of 2, ≥ 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset.
rx  input  1  asynchronous serial line, idle high.
rd_en  input  1  pop FIFO head. Ignored when valid = 0.
clr_err  input  1  clears the sticky error flags.
data  output  DATA_BITS  FIFO head (first-word fall-through). Reads 0 when valid = 0.
valid  output  1  FIFO not empty.
count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
busy  output  1  FSM not in IDLE.
frame_err  output  1  sticky, a stop bit was sampled low.
parity_err  output  1  sticky, parity mismatch.
overrun  output  1  sticky, a good frame arrived while the FIFO was full.

Behaviour:
- Reset (reset = 0 at a clk edge):
  - FSM goes to IDLE, FIFO is emptied, flags are cleared, synchroniser flops are set to 1.
  - All outputs read 0.
  - Applies even mid-frame. The partial frame is discarded.
- rx passes through a 2-flop synchroniser. All sampling uses the synchronised value rxs.
- A bit counter counts 0..CLKS_PER_BIT-1. Sampling happens at mid-bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rxs = 0 → START, counter cleared.
  - START: when the counter reaches CLKS_PER_BIT/2-1, sample rxs.
    - Sample = 1: glitch, return to IDLE, nothing recorded.
    - Sample = 0: go to DATA, counter cleared. This realigns sampling to mid-bit.
  - DATA: sample every CLKS_PER_BIT cycles, shifting LSB first. After DATA_BITS samples → PARITY if PARITY ≠ 0, else → STOP.
  - PARITY: sample the parity bit.
    - Odd parity: the ones count over data plus parity bit must be odd.
    - Even parity: that count must be even.
  - STOP: sample STOP_BITS stop bits, one per CLKS_PER_BIT.
    - Any stop sample = 0: frame_err is set, the frame is dropped, go to WAIT_IDLE.
    - Otherwise, on a parity mismatch: parity_err is set, the frame is dropped, go to IDLE.
    - Otherwise: push the frame and go to IDLE.
  - WAIT_IDLE: stay until rxs = 1, then go to IDLE. A break condition therefore never produces frames.
- Push timing: the push occurs in the cycle of the final stop-bit sample. valid, data and count update on the next clock edge (1-cycle latency).
- Push while the FIFO is full and there is no pop in the same cycle: the frame is dropped, overrun is set, and the FIFO is unchanged.
- Pop: with rd_en = 1 and valid = 1, the head is removed. data shows the next entry, and count decrements, after the edge.
- Simultaneous events:
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: the pop is ignored and the push is accepted.
  - Push and pop in the same cycle otherwise: both succeed, count unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. count is the authoritative full/empty indicator.
- Sticky flags: clr_err = 1 clears all three flags. If a set event and clr_err occur in the same cycle, the flag is set (set wins).
- busy = 1 in every state except IDLE.

Test Plan:
1. Setup CLK_FREQ=16, BAUD=1, 8N1. Send 0x41 → one cycle after the stop-bit mid-sample: valid=1, data=0x41, count=1, no errors. Pulse rd_en → valid=0, data=0, count=0.
2. PARITY=2 (even). Send 0x55 with parity bit 1 → parity_err=1, count=0. Send 0x55 with parity bit 0 → data=0x55. Pulse clr_err → parity_err=0.
3. Send 0xA5 with stop bit 0, then hold rx low for 40 cycles, then high, then send 0x3C → frame_err=1, busy stays 1 until rx rises, FIFO holds only 0x3C.
4. FIFO_DEPTH=4. Send 0x01..0x05 without reads → count=4, overrun=1, data=0x01. Four pops return 0x01, 0x02, 0x03, 0x04, then valid=0.
5. FIFO full. Assert rd_en in the exact cycle 0x05 is pushed → count stays 4, overrun=0, and the tail entry is 0x05. Separately, a 3-cycle low glitch on rx → busy returns to 0 and count is unchanged.
6. Assert reset=0 for one cycle mid-DATA with 2 entries queued → next cycle: valid=0, count=0, busy=0, all flags 0. The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, glitch rejection, error flags
// and a first-word-fall-through receive FIFO with overrun reporting.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          data,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int unsigned CPB    = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W  = $clog2(CPB);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = PTR_W + 1;
    localparam int unsigned BIDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic                 r_sync1;
    logic                 r_rxs;

    state_t               r_state;
    state_t               w_state_n;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [BIDX_W-1:0]    r_bit_idx;
    logic [BIDX_W-1:0]    w_bit_idx_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 r_par_bit;
    logic                 w_par_bit_n;
    logic                 r_stop_bad;
    logic                 w_stop_bad_n;

    logic                 w_half;
    logic                 w_tick;
    logic                 w_stop_any;
    logic                 w_ones_odd;
    logic                 w_par_bad;
    logic                 w_push;
    logic                 w_perr_set;
    logic                 w_ferr_set;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     w_rd_ptr_n;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_n;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_ovr_set;
    logic [DATA_BITS-1:0] w_head_n;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    // Two-flop synchroniser; resets to the idle line level
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    assign w_half     = (r_cnt == CNT_W'(CPB / 2 - 1));
    assign w_tick     = (r_cnt == CNT_W'(CPB - 1));
    assign w_ones_odd = (^r_shift) ^ r_par_bit;
    assign w_par_bad  = (PARITY == 1) ? ~w_ones_odd :
                        (PARITY == 2) ?  w_ones_odd : 1'b0;

    // Receiver state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit_idx  <= w_bit_idx_n;
            r_shift    <= w_shift_n;
            r_par_bit  <= w_par_bit_n;
            r_stop_bad <= w_stop_bad_n;
        end
    end

    // Receiver next-state: all samples taken at mid-bit after start realignment
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt + CNT_W'(1);
        w_bit_idx_n  = r_bit_idx;
        w_shift_n    = r_shift;
        w_par_bit_n  = r_par_bit;
        w_stop_bad_n = r_stop_bad;
        w_push       = 1'b0;
        w_perr_set   = 1'b0;
        w_ferr_set   = 1'b0;
        w_stop_any   = r_stop_bad | ~r_rxs;

        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!r_rxs) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_cnt_n     = '0;
                    w_bit_idx_n = '0;
                    w_state_n   = r_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_n     = '0;
                    w_shift_n   = {r_rxs, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_n = r_bit_idx + BIDX_W'(1);
                    if (r_bit_idx == BIDX_W'(DATA_BITS - 1)) begin
                        w_bit_idx_n  = '0;
                        w_stop_bad_n = 1'b0;
                        w_state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_n      = '0;
                    w_par_bit_n  = r_rxs;
                    w_stop_bad_n = 1'b0;
                    w_state_n    = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_cnt_n = '0;
                    if (r_bit_idx == BIDX_W'(STOP_BITS - 1)) begin
                        w_bit_idx_n = '0;
                        if (w_stop_any) begin
                            w_ferr_set = 1'b1;
                            w_state_n  = S_WAIT_IDLE;
                        end else if (w_par_bad) begin
                            w_perr_set = 1'b1;
                            w_state_n  = S_IDLE;
                        end else begin
                            w_push    = 1'b1;
                            w_state_n = S_IDLE;
                        end
                    end else begin
                        w_stop_bad_n = w_stop_any;
                        w_bit_idx_n  = r_bit_idx + BIDX_W'(1);
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_n = '0;
                if (r_rxs) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // FIFO control; a pop on an empty FIFO is ignored
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = rd_en & (r_count != '0);
    assign w_wr       = w_push & (~w_full | w_pop);
    assign w_ovr_set  = w_push & w_full & ~w_pop;
    assign w_rd_ptr_n = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_n  = r_count + CW'(w_wr) - CW'(w_pop);
    // Next head bypasses the array when the entry is being written this cycle
    assign w_head_n   = (w_wr && (r_wr_ptr == w_rd_ptr_n)) ? r_shift : r_mem[w_rd_ptr_n];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_n;
            r_count  <= w_count_n;
            r_valid  <= (w_count_n != '0);
            r_data   <= (w_count_n != '0) ? w_head_n : '0;
        end
    end

    // Status: sticky flags where a set event wins over clr_err
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_busy <= (w_state_n != S_IDLE);
            r_ferr <= w_ferr_set | (r_ferr & ~clr_err);
            r_perr <= w_perr_set | (r_perr & ~clr_err);
            r_ovr  <= w_ovr_set  | (r_ovr  & ~clr_err);
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign count      = r_count;
    assign busy       = r_busy;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, checked every
// cycle against a frame-level model built from mid-bit sample times and a queue.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ   = 16;
    localparam int unsigned BAUD       = 1;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PARITY     = 2;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int H      = CPB / 2;
    localparam int NPAR   = (PARITY != 0) ? 1 : 0;
    localparam int KF     = DATA_BITS + NPAR + STOP_BITS;
    localparam int NBITS  = KF + 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int POPHIT = H + KF * CPB + 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_FRAME = 1;
    localparam int PH_WAIT  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic rd_en = 1'b0;
    logic clr_err = 1'b0;
    logic [DATA_BITS-1:0] data;
    logic valid;
    logic [CW-1:0] count;
    logic busy, frame_err, parity_err, overrun;

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .PARITY(PARITY), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
        .data(data), .valid(valid), .count(count), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    int cyc = 0;
    int ph = PH_IDLE;
    int t0 = 0;
    int idx, k, ones, sz;
    bit chk_en = 0;
    bit m_s1 = 1, m_rxs = 1;
    bit sbits [0:15];
    bit pop_ev, push_ev, perr_ev, ferr_ev, ovr_ev, stop_ok, par_bad;
    logic [DATA_BITS-1:0] pd;
    logic [DATA_BITS-1:0] mq[$];
    logic e_ferr = 0, e_perr = 0, e_ovr = 0, e_busy = 0, e_valid = 0;
    logic [DATA_BITS-1:0] e_data = '0;
    logic [CW-1:0] e_count = '0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            mq.delete();
            ph = PH_IDLE;
            m_s1 = 1; m_rxs = 1;
            e_ferr = 0; e_perr = 0; e_ovr = 0;
            chk_en = 1;
        end else begin
            sz = mq.size();
            pop_ev = rd_en && (sz > 0);
            push_ev = 0; perr_ev = 0; ferr_ev = 0; ovr_ev = 0;
            case (ph)
                PH_IDLE: if (!m_rxs) begin ph = PH_FRAME; t0 = cyc - 1; end
                PH_FRAME: begin
                    idx = cyc - 1 - t0 - H;
                    if (idx >= 0 && (idx % CPB) == 0) begin
                        k = idx / CPB;
                        sbits[k] = m_rxs;
                        if (k == 0 && m_rxs) begin
                            ph = PH_IDLE;
                        end else if (k == KF) begin
                            for (int j = 0; j < DATA_BITS; j++) pd[j] = sbits[j + 1];
                            stop_ok = 1;
                            for (int j = KF - STOP_BITS + 1; j <= KF; j++)
                                if (!sbits[j]) stop_ok = 0;
                            ones = $countones(pd) + ((NPAR != 0) ? int'(sbits[DATA_BITS + 1]) : 0);
                            par_bad = (PARITY == 1 && ones % 2 == 0) || (PARITY == 2 && ones % 2 == 1);
                            if (!stop_ok) begin ferr_ev = 1; ph = PH_WAIT; end
                            else if (par_bad) begin perr_ev = 1; ph = PH_IDLE; end
                            else begin push_ev = 1; ph = PH_IDLE; end
                        end
                    end
                end
                PH_WAIT: if (m_rxs) ph = PH_IDLE;
                default: ph = PH_IDLE;
            endcase
            if (pop_ev) void'(mq.pop_front());
            if (push_ev) begin
                if (sz == FIFO_DEPTH && !pop_ev) ovr_ev = 1;
                else mq.push_back(pd);
            end
            if (clr_err) begin e_ferr = 0; e_perr = 0; e_ovr = 0; end
            if (ferr_ev) e_ferr = 1;
            if (perr_ev) e_perr = 1;
            if (ovr_ev)  e_ovr  = 1;
            m_rxs = m_s1;
            m_s1  = rx;
        end
        e_busy  = (ph != PH_IDLE);
        e_count = CW'(mq.size());
        e_valid = (mq.size() > 0);
        e_data  = (mq.size() > 0) ? mq[0] : '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(valid), 32'(e_valid));
            chk("data", 32'(data), 32'(e_data));
            chk("count", 32'(count), 32'(e_count));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("frame_err", 32'(frame_err), 32'(e_ferr));
            chk("parity_err", 32'(parity_err), 32'(e_perr));
            chk("overrun", 32'(overrun), 32'(e_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
            rd_en = rnd && ($urandom_range(0, 3) == 0);
            clr_err = rnd && ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        end
    endtask

    task automatic pop1();
        @(negedge clk); rd_en = 1'b1; clr_err = 1'b0;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic clr1();
        @(negedge clk); clr_err = 1'b1; rd_en = 1'b0;
        @(negedge clk); clr_err = 1'b0;
    endtask

    // Drives one frame; rd_en is raised only at offset pop_off, reset pulsed at abort_at
    task automatic send(input logic [7:0] d, input bit pflip, input bit stopv,
                        input int pop_off, input int abort_at);
        logic b [0:15];
        b[0] = 1'b0;
        for (int j = 0; j < DATA_BITS; j++) b[j + 1] = d[j];
        if (NPAR != 0) b[DATA_BITS + 1] = ((PARITY == 2) ? (^d) : ~(^d)) ^ pflip;
        for (int j = DATA_BITS + NPAR + 1; j < NBITS; j++) b[j] = stopv;
        for (int i = 0; i < NBITS * CPB; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                reset = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            rx = b[i / CPB];
            rd_en = (i == pop_off);
            clr_err = 1'b0;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bit pf, sv;
        int po, ab;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({frame_err, parity_err, overrun}), 0);
        idle(10, 0);

        // 1: basic receive and pop
        send(8'h41, 0, 1, -1, -1); idle(4, 0);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_data", 32'(data), 32'h41);
        chk("t1_count", 32'(count), 1);
        chk("t1_errs", 32'({frame_err, parity_err, overrun}), 0);
        pop1();
        chk("t1_pop_valid", 32'(valid), 0);
        chk("t1_pop_data", 32'(data), 0);
        chk("t1_pop_count", 32'(count), 0);

        // 2: even parity
        send(8'h55, 1, 1, -1, -1); idle(4, 0);
        chk("t2_perr", 32'(parity_err), 1);
        chk("t2_count0", 32'(count), 0);
        send(8'h55, 0, 1, -1, -1); idle(4, 0);
        chk("t2_data", 32'(data), 32'h55);
        clr1();
        chk("t2_clr", 32'(parity_err), 0);
        pop1();

        // 3: framing error followed by break
        send(8'hA5, 0, 0, -1, -1); hold_low(40);
        chk("t3_ferr", 32'(frame_err), 1);
        chk("t3_busy_low", 32'(busy), 1);
        idle(20, 0);
        chk("t3_busy_high", 32'(busy), 0);
        send(8'h3C, 0, 1, -1, -1); idle(4, 0);
        chk("t3_count", 32'(count), 1);
        chk("t3_data", 32'(data), 32'h3C);
        pop1(); clr1();

        // 4: overrun
        for (int v = 1; v <= 5; v++) begin send(8'(v), 0, 1, -1, -1); idle(4, 0); end
        chk("t4_count", 32'(count), 4);
        chk("t4_ovr", 32'(overrun), 1);
        chk("t4_head", 32'(data), 1);
        for (int v = 1; v <= 4; v++) begin chk("t4_pop", 32'(data), 32'(v)); pop1(); end
        chk("t4_empty", 32'(valid), 0);

        // 5: pop in the push cycle while full, then a short glitch
        clr1();
        for (int v = 1; v <= 4; v++) begin send(8'(v), 0, 1, -1, -1); idle(4, 0); end
        send(8'h05, 0, 1, POPHIT, -1); idle(4, 0);
        chk("t5_count", 32'(count), 4);
        chk("t5_ovr", 32'(overrun), 0);
        chk("t5_head", 32'(data), 2);
        hold_low(3); idle(20, 0);
        chk("t5_glitch_busy", 32'(busy), 0);
        chk("t5_glitch_count", 32'(count), 4);
        pop1(); pop1(); pop1();
        chk("t5_tail", 32'(data), 5);
        pop1();

        // 6: reset mid-frame
        send(8'h21, 0, 1, -1, -1); idle(4, 0);
        send(8'h22, 0, 1, -1, -1); idle(4, 0);
        send(8'h23, 1, 1, -1, -1); idle(4, 0);
        chk("t6_pre_count", 32'(count), 2);
        chk("t6_pre_perr", 32'(parity_err), 1);
        send(8'h33, 0, 1, -1, 4 * CPB);
        chk("t6_valid", 32'(valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_flags", 32'({frame_err, parity_err, overrun}), 0);
        idle(20, 0);
        send(8'h7E, 0, 1, -1, -1); idle(4, 0);
        chk("t6_data", 32'(data), 32'h7E);
        chk("t6_count1", 32'(count), 1);
        pop1();

        // Random traffic
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                d  = 8'($urandom_range(0, 255));
                pf = ($urandom_range(0, 5) == 0);
                sv = ($urandom_range(0, 7) != 0);
                po = ($urandom_range(0, 2) == 0) ? int'($urandom_range(POPHIT - 3, NBITS * CPB - 1)) : -1;
                ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, NBITS * CPB - 1)) : -1;
                send(d, pf, sv, po, ab);
                if (!sv) hold_low(int'($urandom_range(0, 30)));
            end else begin
                hold_low(int'($urandom_range(1, 5)));
            end
            idle(int'($urandom_range(12, 40)), 1);
        end
        idle(10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
